pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the PC value loaded at reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_4180, SHALL be the PC value loaded on exception or address error.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 stall  input  1  SHALL mean hold PC (pipeline hazard).
REQ-006 redirect  input  1  SHALL mean a branch/jump resolved taken this cycle.
REQ-007 target  input  32  SHALL be the redirect destination, valid with redirect.
REQ-008 exc  input  1  SHALL mean a pipeline exception is raised.
REQ-009 exc_pc  input  32  SHALL be the faulting instruction address, valid with exc.
REQ-010 eret  input  1  SHALL mean return from exception.
REQ-011 halt  input  1  SHALL mean stop fetching.
REQ-012 pc  output  32  SHALL be the current fetch address.
REQ-013 pc_valid  output  1  SHALL mean pc is a legal fetch this cycle.
REQ-014 flush  output  1  SHALL be a one-cycle pulse to kill younger instructions.
REQ-015 addr_err  output  1  SHALL be a one-cycle pulse for a misaligned redirect target.
REQ-016 epc  output  32  SHALL be the saved exception return address.
REQ-017 fetch_cnt  output  32  SHALL count accepted fetches.

Function
REQ-018 States SHALL be BOOT, RUN, PEND, HALT, encoded in a registered state variable.
REQ-019 Per-edge priority SHALL be: exc > addr error > eret > redirect > halt > stall > sequential.
REQ-020 BOOT: pc_valid=0, pc=RESET_PC; next edge SHALL enter RUN without changing pc.
REQ-021 RUN, no event, stall=0: pc <= pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0); stall=1: pc held.
REQ-022 RUN, redirect with target[1:0]==0, stall=0: pc <= target, flush=0.
REQ-023 RUN, redirect with stall=1: target SHALL be captured into a pending register, pc held, state -> PEND.
REQ-024 PEND: pc held while stall=1; first edge with stall=0 SHALL load pc <= pending target and return to RUN; new redirect in PEND SHALL overwrite pending target.
REQ-025 Misaligned redirect (target[1:0]!=0), any state except HALT: epc <= target, pc <= EXC_VECTOR, addr_err=1 and flush=1 next cycle, state -> RUN, stall ignored.
REQ-026 exc in any state: epc <= exc_pc, pc <= EXC_VECTOR, flush=1 next cycle, pending target discarded, state -> RUN, stall ignored.
REQ-027 eret (no exc): pc <= epc, flush=1 next cycle, state -> RUN, stall ignored.
REQ-028 halt (no higher event): state -> HALT; HALT holds pc, pc_valid=0, ignores redirect/stall/eret; only exc or reset leaves HALT.
REQ-029 pc_valid SHALL be 1 in RUN and PEND, 0 in BOOT and HALT.
REQ-030 fetch_cnt SHALL increment (wrapping) on each edge where pc_valid=1 and stall=0.
REQ-031 flush and addr_err SHALL be registered and deassert after exactly one cycle unless retriggered.

Reset
REQ-032 rst_n low SHALL immediately force pc=RESET_PC, state=BOOT, epc=0, pending=0, fetch_cnt=0, pc_valid=0, flush=0, addr_err=0, regardless of clk, including mid-PEND or mid-HALT.
REQ-033 Release of rst_n SHALL be effective at the first following rising clk edge.

Verification
REQ-034 Reset release, no inputs, 4 edges -> pc: 3000 (BOOT), 3000, 3004, 3008; fetch_cnt=2.
REQ-035 RUN pc=3010, redirect target=3100 with stall=1 for 2 cycles -> pc held 3010 in PEND, then 3100, state RUN.
REQ-036 pc=3020, exc with exc_pc=301C plus redirect and stall same cycle -> pc=4180, epc=301C, flush=1 one cycle; then eret -> pc=301C, flush=1.
REQ-037 redirect target=3102 -> pc=4180, epc=3102, addr_err=1 and flush=1 for one cycle.
REQ-038 halt at pc=3040, then redirect and eret -> pc stays 3040, pc_valid=0; exc -> pc=4180, RUN.
REQ-039 rst_n asserted mid-PEND between clock edges -> outputs at reset values immediately, pending target not applied after release.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer for an in-order pipeline.
// Produces the fetch PC and applies, in priority order, exceptions,
// misaligned-redirect address errors, exception return, branch/jump
// redirects, halt, stall and sequential advance. It saves the exception
// return address and counts accepted fetches.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   stall      in   1   hold pc (pipeline hazard)
//   redirect   in   1   branch/jump resolved taken this cycle
//   target     in  32   redirect destination, valid with redirect
//   exc        in   1   pipeline exception raised
//   exc_pc     in  32   faulting instruction address, valid with exc
//   eret       in   1   return from exception
//   halt       in   1   stop fetching
//   pc         out 32   current fetch address
//   pc_valid   out  1   pc is a legal fetch this cycle
//   flush      out  1   one-cycle pulse, kill younger instructions
//   addr_err   out  1   one-cycle pulse, misaligned redirect target
//   epc        out 32   saved exception return address
//   fetch_cnt  out 32   count of accepted fetches (wraps)
//
// state | meaning
// ------+------------------------------------------------------------
// BOOT  | out of reset, pc = RESET_PC, no fetch yet
// RUN   | fetching; pc advances, redirects, or holds on stall
// PEND  | taken redirect arrived under stall; target parked in pend_pc
// HALT  | fetch stopped, pc frozen; only exc (or reset) leaves
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] target,
    input  logic        exc,
    input  logic [31:0] exc_pc,
    input  logic        eret,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic        addr_err,
    output logic [31:0] epc,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] epc_nxt;
    logic [31:0] pend_pc, pend_nxt;
    logic        flush_nxt;
    logic        addr_err_nxt;
    logic        misaligned;

    assign misaligned = redirect && (target[1:0] != 2'b00);
    assign pc_valid   = (state == RUN) || (state == PEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            epc       <= 32'h0;
            pend_pc   <= 32'h0;
            flush     <= 1'b0;
            addr_err  <= 1'b0;
            fetch_cnt <= 32'h0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            epc      <= epc_nxt;
            pend_pc  <= pend_nxt;
            flush    <= flush_nxt;
            addr_err <= addr_err_nxt;
            if (pc_valid && !stall) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        epc_nxt      = epc;
        pend_nxt     = pend_pc;
        flush_nxt    = 1'b0;
        addr_err_nxt = 1'b0;

        if (exc) begin
            // Exceptions win everywhere, including HALT, and drop any parked target.
            epc_nxt   = exc_pc;
            pc_nxt    = EXC_VECTOR;
            pend_nxt  = 32'h0;
            flush_nxt = 1'b1;
            state_nxt = RUN;
        end else if ((state != HALT) && misaligned) begin
            epc_nxt      = target;
            pc_nxt       = EXC_VECTOR;
            pend_nxt     = 32'h0;
            flush_nxt    = 1'b1;
            addr_err_nxt = 1'b1;
            state_nxt    = RUN;
        end else begin
            case (state)
                BOOT: begin
                    if (eret) begin
                        pc_nxt    = epc;
                        flush_nxt = 1'b1;
                        state_nxt = RUN;
                    end else if (halt) begin
                        state_nxt = HALT;
                    end else begin
                        // First fetch is RESET_PC itself, so pc is not advanced here.
                        state_nxt = RUN;
                    end
                end
                RUN, PEND: begin
                    if (eret) begin
                        pc_nxt    = epc;
                        pend_nxt  = 32'h0;
                        flush_nxt = 1'b1;
                        state_nxt = RUN;
                    end else if (redirect) begin
                        // A newer redirect always replaces a parked one.
                        if (stall) begin
                            pend_nxt  = target;
                            state_nxt = PEND;
                        end else begin
                            pc_nxt    = target;
                            state_nxt = RUN;
                        end
                    end else if (halt) begin
                        state_nxt = HALT;
                    end else if (!stall) begin
                        pc_nxt    = (state == PEND) ? pend_pc : pc + 32'd4;
                        state_nxt = RUN;
                    end
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: begin
                    state_nxt = BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_V  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = 32'h0;
    logic        exc = 1'b0;
    logic [31:0] exc_pc = 32'h0;
    logic        eret = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        addr_err;
    logic [31:0] epc;
    logic [31:0] fetch_cnt;

    pc_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .redirect  (redirect),
        .target    (target),
        .exc       (exc),
        .exc_pc    (exc_pc),
        .eret      (eret),
        .halt      (halt),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .flush     (flush),
        .addr_err  (addr_err),
        .epc       (epc),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        pc_valid;
        logic        flush;
        logic        addr_err;
        logic [31:0] epc;
        logic [31:0] fetch_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: abstract modes named after the spec's states.
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_PEND = 2;
    localparam int M_HALT = 3;

    int          m_mode;
    logic [31:0] m_pc, m_epc, m_pend, m_cnt;
    logic        m_flush, m_aerr;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_mode  = M_BOOT;
        m_pc    = RST_PC;
        m_epc   = 32'h0;
        m_pend  = 32'h0;
        m_cnt   = 32'h0;
        m_flush = 1'b0;
        m_aerr  = 1'b0;
    endfunction

    function automatic void model_step(input logic s, input logic r, input logic [31:0] t,
                                       input logic e, input logic [31:0] ep,
                                       input logic er, input logic h);
        bit fetching;
        fetching = (m_mode == M_RUN) || (m_mode == M_PEND);
        if (fetching && !s) m_cnt = m_cnt + 32'd1;
        m_flush = 1'b0;
        m_aerr  = 1'b0;
        if (e) begin
            m_epc = ep; m_pc = EXC_V; m_flush = 1'b1; m_mode = M_RUN;
        end else if (m_mode != M_HALT && r && t[1:0] != 2'b00) begin
            m_epc = t; m_pc = EXC_V; m_flush = 1'b1; m_aerr = 1'b1; m_mode = M_RUN;
        end else if (m_mode == M_HALT) begin
            m_mode = M_HALT;
        end else if (er) begin
            m_pc = m_epc; m_flush = 1'b1; m_mode = M_RUN;
        end else if (m_mode == M_BOOT) begin
            m_mode = h ? M_HALT : M_RUN;
        end else if (r) begin
            if (s) begin
                m_pend = t; m_mode = M_PEND;
            end else begin
                m_pc = t; m_mode = M_RUN;
            end
        end else if (h) begin
            m_mode = M_HALT;
        end else if (!s) begin
            if (m_mode == M_PEND) m_pc = m_pend;
            else m_pc = m_pc + 32'd4;
            m_mode = M_RUN;
        end
    endfunction

    function automatic void push_expect();
        exp_t x;
        x.pc        = m_pc;
        x.pc_valid  = (m_mode == M_RUN) || (m_mode == M_PEND);
        x.flush     = m_flush;
        x.addr_err  = m_aerr;
        x.epc       = m_epc;
        x.fetch_cnt = m_cnt;
        exp_q.push_back(x);
    endfunction

    task automatic drive(input logic s, input logic r, input logic [31:0] t, input logic e,
                         input logic [31:0] ep, input logic er, input logic h);
        @(negedge clk);
        stall = s; redirect = r; target = t; exc = e; exc_pc = ep; eret = er; halt = h;
        model_step(s, r, t, e, ep, er, h);
        push_expect();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Reset pulse placed between clock edges; released before the next rising edge.
    task automatic reset_seq();
        @(negedge clk);
        stall = 0; redirect = 0; target = 0; exc = 0; exc_pc = 0; eret = 0; halt = 0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_pc", pc, RST_PC);
        check("rst_pc_valid", 32'(pc_valid), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_epc", epc, 32'h0);
        check("rst_fetch_cnt", fetch_cnt, 32'h0);
        model_reset();
        #1 rst_n = 1'b1;
        model_step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        push_expect();
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("mon_pc", pc, x.pc);
                check("mon_pc_valid", 32'(pc_valid), 32'(x.pc_valid));
                check("mon_flush", 32'(flush), 32'(x.flush));
                check("mon_addr_err", 32'(addr_err), 32'(x.addr_err));
                check("mon_epc", epc, x.epc);
                check("mon_fetch_cnt", fetch_cnt, x.fetch_cnt);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic        s, r, e, er, h;
        logic [31:0] t, ep;
        model_reset();

        // Reset release and sequential fetch
        reset_seq();
        settle();
        check("boot_pc", pc, 32'h3000);
        idle(); idle();
        settle();
        check("seq_pc", pc, 32'h3008);
        check("seq_fetch_cnt", fetch_cnt, 32'd2);

        // Redirect under stall parks, then applies
        idle(); idle();
        settle();
        check("pre_pend_pc", pc, 32'h3010);
        drive(1'b1, 1'b1, 32'h3100, 1'b0, 32'h0, 1'b0, 1'b0);
        settle();
        check("pend_hold1", pc, 32'h3010);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        settle();
        check("pend_hold2", pc, 32'h3010);
        idle();
        settle();
        check("pend_apply", pc, 32'h3100);

        // Exception beats redirect and stall; then eret
        reset_seq();
        repeat (8) idle();
        settle();
        check("exc_pre_pc", pc, 32'h3020);
        drive(1'b1, 1'b1, 32'h3200, 1'b1, 32'h301C, 1'b0, 1'b0);
        settle();
        check("exc_pc", pc, EXC_V);
        check("exc_epc", epc, 32'h301C);
        check("exc_flush", 32'(flush), 32'd1);
        idle();
        settle();
        check("exc_flush_drop", 32'(flush), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        settle();
        check("eret_pc", pc, 32'h301C);
        check("eret_flush", 32'(flush), 32'd1);

        // Misaligned redirect
        drive(1'b0, 1'b1, 32'h3102, 1'b0, 32'h0, 1'b0, 1'b0);
        settle();
        check("aerr_pc", pc, EXC_V);
        check("aerr_epc", epc, 32'h3102);
        check("aerr_pulse", 32'(addr_err), 32'd1);
        check("aerr_flush", 32'(flush), 32'd1);
        idle();
        settle();
        check("aerr_drop", 32'(addr_err), 32'd0);

        // Halt ignores redirect/eret, exc leaves
        reset_seq();
        repeat (16) idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        settle();
        check("halt_pc", pc, 32'h3040);
        check("halt_valid", 32'(pc_valid), 32'd0);
        drive(1'b0, 1'b1, 32'h3300, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        settle();
        check("halt_hold_pc", pc, 32'h3040);
        check("halt_hold_valid", 32'(pc_valid), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h3044, 1'b0, 1'b0);
        settle();
        check("halt_exit_pc", pc, EXC_V);
        check("halt_exit_valid", 32'(pc_valid), 32'd1);

        // Reset in the middle of PEND discards the parked target
        drive(1'b1, 1'b1, 32'h3500, 1'b0, 32'h0, 1'b0, 1'b0);
        reset_seq();
        settle();
        idle();
        settle();
        check("rst_pend_pc", pc, 32'h3004);

        // Wrap at the top of the address space
        drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(); idle();
        settle();
        check("wrap_pc", pc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset_seq();
            end else begin
                s  = ($urandom_range(0, 2) == 0);
                r  = ($urandom_range(0, 5) == 0);
                t  = $urandom() & 32'hFFFF_FFFC;
                if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
                e  = ($urandom_range(0, 31) == 0);
                ep = $urandom();
                er = ($urandom_range(0, 31) == 0);
                h  = ($urandom_range(0, 39) == 0);
                drive(s, r, t, e, ep, er, h);
            end
        end

        settle();
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
